mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage plus MEM/WB pipeline register. It sits directly upstream of the write-back stage and takes the EX/MEM bundle. It issues loads and stores to a multi-cycle data memory over a req/ack handshake, and stalls the front of the pipeline until the access completes. It then registers readData, ALUResult, PC_2, i8SE and the WB control bits, which are consumed by the write-back mux.

Parameters:
TIMEOUT, 255, max cycles spent waiting for mem_ack before a fatal error (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  EX/MEM bundle holds a real instruction
in_MemRead  in  1  load
in_MemWrite  in  1  store
in_ALUResult  in  16  effective address / ALU result
in_storeData  in  16  store data
in_PC_2  in  16  PC+2
in_i8SE  in  16  sign-extended imm8
in_MemToReg, in_PCtoReg, in_LBI_sel, in_RegWrite  in  1 each  WB control
in_writeReg  in  3  destination register
mem_req  out  1  memory request
mem_wr  out  1  1=store, 0=load
mem_addr  out  16  word-aligned address
mem_wdata  out  16  store data
mem_rdata  in  16  load data, valid with mem_ack
mem_ack  in  1  access complete (same cycle as req allowed)
stall  out  1  hold EX/MEM and all earlier stages
out_valid  out  1  MEM/WB entry valid
out_readData, out_ALUResult, out_PC_2, out_i8SE  out  16 each  to WB
out_MemToReg, out_PCtoReg, out_LBI_sel, out_RegWrite  out  1 each  to WB
out_writeReg  out  3  to WB
err  out  1  sticky fatal error

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, timeout counter=0, all out_* = 0, err=0. mem_req and stall are forced 0.
- Reset asserted mid-WAIT: the access is abandoned and mem_req drops immediately. A late mem_ack after reset is ignored.
- memop = in_valid & (in_MemRead | in_MemWrite).
- FSM states:
  - IDLE: if memop and legal, assert mem_req combinationally. If mem_ack is high the same cycle, complete (1-cycle, no stall). Otherwise go to WAIT.
  - WAIT: hold mem_req with mem_addr, mem_wr and mem_wdata stable; counter++. On mem_ack, complete and go to IDLE. When counter reaches TIMEOUT, go to ERR.
  - ERR: mem_req=0, stall=1, err=1. Only reset exits ERR.
- mem_addr = in_ALUResult; mem_wr = in_MemWrite; mem_wdata = in_storeData.
- stall = (memop & ~mem_ack & state!=ERR) | (state==ERR).
- Complete: at the clock edge, latch the full bundle into MEM/WB and set out_valid=1.
  - Load: out_readData = mem_rdata.
  - Store: out_readData = 0 and out_RegWrite = in_RegWrite as given.
- Non-memory instruction: MEM/WB captures the bundle at the next edge (latency 1), and out_readData=0.
- While stall=1 (waiting): MEM/WB loads a bubble (out_valid=0, out_RegWrite=0, other fields 0), so WB never writes twice.
- in_valid=0: bubble is loaded.
- Illegal access, checked in IDLE before any request:
  - Cases: MemRead & MemWrite both 1, or in_ALUResult[0]=1 on a memop.
  - Response: no mem_req issued; go to ERR and set err at the next edge.
- mem_ack while mem_req=0: ignored.
- Counter is 8-bit, cleared on every entry to WAIT and on completion, and never wraps.

Decomposition:
- Shared header mem_stage_defs: FSM state encodings (IDLE=2'd0, WAIT=2'd1, ERR=2'd2) and the default TIMEOUT constant.
- One sub-module, mem_wb_reg: the MEM/WB pipeline register with async active-low reset and bubble-insert input.

Test Plan:
- Reset, then ALU op (in_ALUResult=16'h1234, RegWrite=1, no memop) -> next edge: out_valid=1, out_ALUResult=16'h1234, out_readData=0, stall never 1.
- Load addr 16'h0040, mem_ack same cycle, mem_rdata=16'hBEEF -> no stall; next edge out_readData=16'hBEEF, out_MemToReg passed through.
- Store addr 16'h0010, data 16'h00AA, ack after 3 cycles -> mem_req high 4 cycles, stall high 3 cycles with addr/wdata stable, bubbles for 3 cycles, then one valid entry.
- Load with ack withheld (TIMEOUT=4) -> ERR after 4 WAIT cycles: err=1, mem_req=0, stall=1 held until reset.
- Load at odd address 16'h0021 -> mem_req never asserts; err=1 after one edge.
- rst_n pulsed low during WAIT -> mem_req, stall, out_valid drop immediately; a later mem_ack produces no MEM/WB entry.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encodings, default timeout,
// the MEM/WB bundle layout and the illegal-access predicate.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    typedef struct packed {
        logic        valid;
        logic [15:0] read_data;
        logic [15:0] alu_result;
        logic [15:0] pc_2;
        logic [15:0] i8se;
        logic        mem_to_reg;
        logic        pc_to_reg;
        logic        lbi_sel;
        logic        reg_write;
        logic [2:0]  write_reg;
    } wb_bundle_t;

    // A memory op is illegal when it asks for both read and write, or when
    // its address is not word aligned.
    function automatic logic is_illegal(input logic        mem_read,
                                        input logic        mem_write,
                                        input logic [15:0] addr);
        return (mem_read & mem_write) | addr[0];
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus. The stage is the master, the memory
// model is the slave.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the whole entry so that the
// write-back stage can never see a stale RegWrite.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble_i,
    input  wb_bundle_t bundle_d,
    output wb_bundle_t bundle_q
);

    // Capture the next entry, or an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= '0;
        end else if (bubble_i) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores over a req/ack bus, stalls the front of
// the pipeline while an access is outstanding, and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_MemRead,
    input  logic          in_MemWrite,
    input  logic [15:0]   in_ALUResult,
    input  logic [15:0]   in_storeData,
    input  logic [15:0]   in_PC_2,
    input  logic [15:0]   in_i8SE,
    input  logic          in_MemToReg,
    input  logic          in_PCtoReg,
    input  logic          in_LBI_sel,
    input  logic          in_RegWrite,
    input  logic [2:0]    in_writeReg,
    mem_stage_if.master   mem,
    output logic          stall,
    output logic          out_valid,
    output logic [15:0]   out_readData,
    output logic [15:0]   out_ALUResult,
    output logic [15:0]   out_PC_2,
    output logic [15:0]   out_i8SE,
    output logic          out_MemToReg,
    output logic          out_PCtoReg,
    output logic          out_LBI_sel,
    output logic          out_RegWrite,
    output logic [2:0]    out_writeReg,
    output logic          err
);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       err_q;

    logic       memop_s;
    logic       illegal_s;
    logic       req_s;
    logic       ack_s;
    logic       stall_s;
    logic       bubble_s;
    wb_bundle_t wb_d_s;
    wb_bundle_t wb_q_s;

    // Request/stall decode; both are forced low while reset is asserted so an
    // abandoned access drops its request immediately.
    always_comb begin
        memop_s   = in_valid & (in_MemRead | in_MemWrite);
        illegal_s = memop_s & is_illegal(in_MemRead, in_MemWrite, in_ALUResult);
        req_s     = 1'b0;
        case (state_q)
            ST_IDLE: req_s = memop_s & ~illegal_s;
            ST_WAIT: req_s = 1'b1;
            ST_ERR:  req_s = 1'b0;
            default: req_s = 1'b0;
        endcase
        req_s   = req_s & rst_n;
        // An acknowledge with no request outstanding is meaningless.
        ack_s   = mem.mem_ack & req_s;
        stall_s = rst_n & ((memop_s & ~ack_s & (state_q != ST_ERR)) |
                           (state_q == ST_ERR));
        // Anything that stalls, or no instruction at all, becomes a bubble.
        bubble_s = ~in_valid | stall_s;
    end

    // Next MEM/WB entry; read data only comes from memory on a load.
    always_comb begin
        wb_d_s            = '0;
        wb_d_s.valid      = 1'b1;
        wb_d_s.alu_result = in_ALUResult;
        wb_d_s.pc_2       = in_PC_2;
        wb_d_s.i8se       = in_i8SE;
        wb_d_s.mem_to_reg = in_MemToReg;
        wb_d_s.pc_to_reg  = in_PCtoReg;
        wb_d_s.lbi_sel    = in_LBI_sel;
        wb_d_s.reg_write  = in_RegWrite;
        wb_d_s.write_reg  = in_writeReg;
        if (memop_s && in_MemRead) begin
            wb_d_s.read_data = mem.mem_rdata;
        end else begin
            wb_d_s.read_data = 16'h0000;
        end
    end

    // Access FSM with wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 8'd0;
                    if (illegal_s) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else if (req_s && !ack_s) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ack_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q >= (TIMEOUT - 8'd1)) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        // Saturating guard: the counter never wraps.
                        cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                    err_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (bubble_s),
        .bundle_d (wb_d_s),
        .bundle_q (wb_q_s)
    );

    assign mem.mem_req   = req_s;
    assign mem.mem_wr    = in_MemWrite;
    assign mem.mem_addr  = in_ALUResult;
    assign mem.mem_wdata = in_storeData;
    assign stall         = stall_s;
    assign err           = err_q;

    assign out_valid     = wb_q_s.valid;
    assign out_readData  = wb_q_s.read_data;
    assign out_ALUResult = wb_q_s.alu_result;
    assign out_PC_2      = wb_q_s.pc_2;
    assign out_i8SE      = wb_q_s.i8se;
    assign out_MemToReg  = wb_q_s.mem_to_reg;
    assign out_PCtoReg   = wb_q_s.pc_to_reg;
    assign out_LBI_sel   = wb_q_s.lbi_sel;
    assign out_RegWrite  = wb_q_s.reg_write;
    assign out_writeReg  = wb_q_s.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written
// sequences for wait states, timeout, illegal accesses and mid-access reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_MemRead, in_MemWrite;
    logic [15:0] in_ALUResult, in_storeData, in_PC_2, in_i8SE;
    logic        in_MemToReg, in_PCtoReg, in_LBI_sel, in_RegWrite;
    logic [2:0]  in_writeReg;
    logic        stall, out_valid;
    logic [15:0] out_readData, out_ALUResult, out_PC_2, out_i8SE;
    logic        out_MemToReg, out_PCtoReg, out_LBI_sel, out_RegWrite;
    logic [2:0]  out_writeReg;
    logic        err;

    int tests = 0;
    int fails = 0;

    mem_stage_if mif ();

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(8'd4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_MemRead    (in_MemRead),
        .in_MemWrite   (in_MemWrite),
        .in_ALUResult  (in_ALUResult),
        .in_storeData  (in_storeData),
        .in_PC_2       (in_PC_2),
        .in_i8SE       (in_i8SE),
        .in_MemToReg   (in_MemToReg),
        .in_PCtoReg    (in_PCtoReg),
        .in_LBI_sel    (in_LBI_sel),
        .in_RegWrite   (in_RegWrite),
        .in_writeReg   (in_writeReg),
        .mem           (mif),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_readData  (out_readData),
        .out_ALUResult (out_ALUResult),
        .out_PC_2      (out_PC_2),
        .out_i8SE      (out_i8SE),
        .out_MemToReg  (out_MemToReg),
        .out_PCtoReg   (out_PCtoReg),
        .out_LBI_sel   (out_LBI_sel),
        .out_RegWrite  (out_RegWrite),
        .out_writeReg  (out_writeReg),
        .err           (err)
    );

    typedef struct {
        logic        v, rd, wr, ack, rw, m2r;
        logic [15:0] alu, sd, rdata;
        logic        exp_req, exp_stall, exp_valid;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0;
        in_ALUResult = 16'h0000; in_storeData = 16'h0000;
        in_PC_2 = 16'h0000; in_i8SE = 16'h0000;
        in_MemToReg = 1'b0; in_PCtoReg = 1'b0; in_LBI_sel = 1'b0;
        in_RegWrite = 1'b0; in_writeReg = 3'd0;
        mif.mem_rdata = 16'h0000; mif.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_mem(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] sd);
        in_valid = 1'b1; in_MemRead = rd; in_MemWrite = wr;
        in_ALUResult = addr; in_storeData = sd;
        in_MemToReg = rd; in_RegWrite = rd; in_writeReg = 3'd5;
        in_PC_2 = 16'h0200; in_i8SE = 16'h0007;
    endtask

    initial begin
        // {v, rd, wr, ack, rw, m2r, alu, sd, rdata, exp_req, exp_stall, exp_valid, exp_rdata}
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h00AA, 16'h7777, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0042, 16'h0000, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h1357, 1'b1, 1'b0, 1'b1, 16'h1357};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h0000};

        // Reset state, with a legal load presented while reset is held.
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        drive_mem(1'b1, 1'b0, 16'h0040, 16'h0000);
        #1;
        chk("rst_req", {15'd0, mif.mem_req}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_alu", out_ALUResult, 16'h0000);
        do_reset();

        // Single-cycle vectors.
        for (int i = 0; i < 7; i++) begin
            logic [15:0] idx;
            idx = 16'(i);
            in_valid = vecs[i].v; in_MemRead = vecs[i].rd; in_MemWrite = vecs[i].wr;
            in_ALUResult = vecs[i].alu; in_storeData = vecs[i].sd;
            in_RegWrite = vecs[i].rw; in_MemToReg = vecs[i].m2r;
            in_PC_2 = 16'h0100 + idx * 16'd2; in_i8SE = {12'hFFF, idx[3:0]};
            in_PCtoReg = idx[0]; in_LBI_sel = idx[1]; in_writeReg = idx[2:0];
            mif.mem_ack = vecs[i].ack; mif.mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {15'd0, mif.mem_req}, {15'd0, vecs[i].exp_req});
            chk($sformatf("v%0d_stall", i), {15'd0, stall}, {15'd0, vecs[i].exp_stall});
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d_addr", i), mif.mem_addr, vecs[i].alu);
                chk($sformatf("v%0d_wr", i), {15'd0, mif.mem_wr}, {15'd0, vecs[i].wr});
            end
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_rdata", i), out_readData, vecs[i].exp_rdata);
            chk($sformatf("v%0d_alu", i), out_ALUResult,
                vecs[i].exp_valid ? vecs[i].alu : 16'h0000);
            chk($sformatf("v%0d_rw", i), {15'd0, out_RegWrite},
                {15'd0, vecs[i].exp_valid & vecs[i].rw});
            chk($sformatf("v%0d_m2r", i), {15'd0, out_MemToReg},
                {15'd0, vecs[i].exp_valid & vecs[i].m2r});
            chk($sformatf("v%0d_pc2", i), out_PC_2,
                vecs[i].exp_valid ? 16'h0100 + idx * 16'd2 : 16'h0000);
            chk($sformatf("v%0d_i8", i), out_i8SE,
                vecs[i].exp_valid ? {12'hFFF, idx[3:0]} : 16'h0000);
            chk($sformatf("v%0d_wreg", i), {13'd0, out_writeReg},
                vecs[i].exp_valid ? {13'd0, idx[2:0]} : 16'h0000);
            chk($sformatf("v%0d_err", i), {15'd0, err}, 16'd0);
        end
        clear_inputs();
        @(negedge clk);

        // Store with ack on the fourth request cycle.
        drive_mem(1'b0, 1'b1, 16'h0010, 16'h00AA);
        in_RegWrite = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mif.mem_ack = (k == 3);
            #1;
            chk($sformatf("st%0d_req", k), {15'd0, mif.mem_req}, 16'd1);
            chk($sformatf("st%0d_stall", k), {15'd0, stall}, (k < 3) ? 16'd1 : 16'd0);
            chk($sformatf("st%0d_addr", k), mif.mem_addr, 16'h0010);
            chk($sformatf("st%0d_wdata", k), mif.mem_wdata, 16'h00AA);
            @(negedge clk);
            chk($sformatf("st%0d_valid", k), {15'd0, out_valid}, (k == 3) ? 16'd1 : 16'd0);
        end
        chk("st_rdata", out_readData, 16'h0000);
        chk("st_alu", out_ALUResult, 16'h0010);
        clear_inputs();
        @(negedge clk);
        chk("st_after_valid", {15'd0, out_valid}, 16'd0);

        // Load with ack withheld: one IDLE cycle, four WAIT cycles, then ERR.
        drive_mem(1'b1, 1'b0, 16'h0080, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("to%0d_req", k), {15'd0, mif.mem_req}, 16'd1);
            chk($sformatf("to%0d_stall", k), {15'd0, stall}, 16'd1);
            @(negedge clk);
            chk($sformatf("to%0d_err", k), {15'd0, err}, (k == 4) ? 16'd1 : 16'd0);
            chk($sformatf("to%0d_valid", k), {15'd0, out_valid}, 16'd0);
        end
        in_valid = 1'b0;
        mif.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("err%0d_req", k), {15'd0, mif.mem_req}, 16'd0);
            chk($sformatf("err%0d_stall", k), {15'd0, stall}, 16'd1);
            @(negedge clk);
            chk($sformatf("err%0d_err", k), {15'd0, err}, 16'd1);
        end
        do_reset();
        #1;
        chk("err_clr", {15'd0, err}, 16'd0);
        chk("err_clr_stall", {15'd0, stall}, 16'd0);
        @(negedge clk);

        // Misaligned load: no request, error after one edge.
        drive_mem(1'b1, 1'b0, 16'h0021, 16'h0000);
        #1;
        chk("odd_req", {15'd0, mif.mem_req}, 16'd0);
        chk("odd_stall", {15'd0, stall}, 16'd1);
        @(negedge clk);
        chk("odd_err", {15'd0, err}, 16'd1);
        chk("odd_req2", {15'd0, mif.mem_req}, 16'd0);
        do_reset();
        @(negedge clk);

        // Read and write both set: illegal even when aligned.
        drive_mem(1'b1, 1'b1, 16'h0020, 16'h0055);
        mif.mem_ack = 1'b1;
        #1;
        chk("rw_req", {15'd0, mif.mem_req}, 16'd0);
        chk("rw_stall", {15'd0, stall}, 16'd1);
        @(negedge clk);
        chk("rw_err", {15'd0, err}, 16'd1);
        chk("rw_valid", {15'd0, out_valid}, 16'd0);
        do_reset();
        @(negedge clk);

        // Reset pulsed during WAIT; a late ack must produce no entry.
        drive_mem(1'b1, 1'b0, 16'h0060, 16'h0000);
        @(negedge clk);
        #1;
        chk("mr_wait_req", {15'd0, mif.mem_req}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_req", {15'd0, mif.mem_req}, 16'd0);
        chk("mr_stall", {15'd0, stall}, 16'd0);
        chk("mr_valid", {15'd0, out_valid}, 16'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 16'hDEAD;
        #1;
        chk("mr_late_req", {15'd0, mif.mem_req}, 16'd0);
        @(negedge clk);
        chk("mr_late_valid", {15'd0, out_valid}, 16'd0);
        chk("mr_late_rdata", out_readData, 16'h0000);
        chk("mr_late_err", {15'd0, err}, 16'd0);
        clear_inputs();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
